// File: rtl/sprite_pkg.sv
// sprite_pkg: shared types and constants for the sprite renderers.
// Holds the default sprite geometry, the 24-bit colour struct and the
// 8-entry tree palette. Index 0 is reserved as the transparent colour.
package sprite_pkg;

  localparam int SPR_W_DEFAULT   = 20;
  localparam int SPR_H_DEFAULT   = 20;
  localparam int TRANSPARENT_IDX = 0;
  localparam int PALETTE_SIZE    = 8;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Entry 0 is never shown (transparent); it is kept black so an
  // accidental lookup still yields a neutral colour.
  localparam rgb_t PALETTE [PALETTE_SIZE] = '{
    24'h000000,
    24'h1E5A1E,
    24'h3C963C,
    24'h6E4614,
    24'h78C850,
    24'h4A2C0A,
    24'h0F3A0F,
    24'hFFFFFF
  };

endpackage

// File: rtl/sprite_palette.sv
// sprite_palette: registered palette lookup.
// On each clock the output colour becomes PALETTE[idx] when en is high,
// otherwise black. Intended as the final pipeline stage of any sprite
// renderer; en is normally the opaque/hit decision for the same slot.
module sprite_palette
  import sprite_pkg::*;
#(
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [IDX_W-1:0] idx,
  output rgb_t             rgb
);

  // Colour register: black under reset or when the slot is not opaque.
  always_ff @(posedge clk) begin
    if (reset) begin
      rgb <= '0;
    end else if (en) begin
      rgb <= PALETTE[idx];
    end else begin
      rgb <= '0;
    end
  end

endmodule

// File: rtl/tree_sprite_renderer.sv
// tree_sprite_renderer: per-pixel tree sprite renderer.
//
// Pipeline (one pixel per clock, no stalls):
//   stage 1: coordinate -> sprite-relative offset, in-box test, RAM address
//   stage 2: external frame RAM returns ram_data (1-cycle read)
//   stage 3: palette lookup, opaque flag -> hit / red / green / blue
// A coordinate sampled at edge N produces hit/RGB after edge N+2.
//
// There is no valid/ready handshake anywhere in this block: pix_valid is a
// per-cycle qualifier that travels with the pixel, every cycle is accepted,
// and the consumer cannot push back.
//
// The sprite position is shadowed into lat_x/lat_y only on frame_start, so
// moving pos_x/pos_y mid-frame cannot tear the image.
//
// Build option: define TREE_SCALE2_EN for 2x pixel doubling (40x40 on-screen
// footprint for a 20x20 sprite). Latency is the same in both builds.
module tree_sprite_renderer
  import sprite_pkg::*;
#(
  parameter int SPR_W  = SPR_W_DEFAULT,
  parameter int SPR_H  = SPR_H_DEFAULT,
  parameter int ADDR_W = 19,
  parameter int DATA_W = 5,
  parameter int PAL_W  = 3
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_start,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              pix_valid,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_data,
  output logic              hit,
  output logic [7:0]        red,
  output logic [7:0]        green,
  output logic [7:0]        blue
);

`ifdef TREE_SCALE2_EN
  localparam int SCALE_SHIFT = 1;
`else
  localparam int SCALE_SHIFT = 0;
`endif

  // On-screen footprint of the sprite in screen pixels.
  localparam logic [9:0] FOOT_W = 10'(SPR_W << SCALE_SHIFT);
  localparam logic [9:0] FOOT_H = 10'(SPR_H << SCALE_SHIFT);

  // Shadowed sprite position.
  logic [9:0] lat_x;
  logic [9:0] lat_y;

  // Stage-1 combinational terms.
  logic [9:0]        lx;
  logic [9:0]        ly;
  logic [9:0]        tx;
  logic [9:0]        ty;
  logic              in_box;
  logic [ADDR_W-1:0] addr_next;

  // Pipeline in-box flags: in_box_q is aligned with ram_addr,
  // in_box_d2 with ram_data.
  logic in_box_q;
  logic in_box_d2;

  // Stage-3 terms.
  logic [PAL_W-1:0] idx;
  logic             pix_hit;
  rgb_t             rgb;

  // Bits of ram_data above the palette index carry no colour information.
  logic unused_ram_hi;
  assign unused_ram_hi = ^ram_data[DATA_W-1:PAL_W];

  // Position shadow: load once per frame so the tree never moves mid-frame.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      lat_x <= '0;
      lat_y <= '0;
    end else if (frame_start) begin
      lat_x <= pos_x;
      lat_y <= pos_y;
    end
  end

  // Stage-1 address math. The >= checks stop a coordinate left of or above
  // the sprite from aliasing into the box through 10-bit wraparound.
  always_comb begin
    lx        = DrawX - lat_x;
    ly        = DrawY - lat_y;
    tx        = lx >> SCALE_SHIFT;
    ty        = ly >> SCALE_SHIFT;
    in_box    = pix_valid
              && (DrawX >= lat_x)
              && (DrawY >= lat_y)
              && (lx < FOOT_W)
              && (ly < FOOT_H);
    addr_next = '0;
    if (in_box) begin
      addr_next = ADDR_W'(ty) * ADDR_W'(SPR_W) + ADDR_W'(tx);
    end
  end

  // Stage-1 register: RAM read address plus its in-box flag.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ram_addr <= '0;
      in_box_q <= 1'b0;
    end else begin
      ram_addr <= addr_next;
      in_box_q <= in_box;
    end
  end

  // Stage-2 register: delay in-box to line up with the RAM's read data.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      in_box_d2 <= 1'b0;
    end else begin
      in_box_d2 <= in_box_q;
    end
  end

  // Stage-3 opaque decision from the palette index.
  always_comb begin
    idx     = ram_data[PAL_W-1:0];
    pix_hit = in_box_d2 && (idx != PAL_W'(TRANSPARENT_IDX));
  end

  // Stage-3 hit register, aligned with the palette's colour register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      hit <= 1'b0;
    end else begin
      hit <= pix_hit;
    end
  end

  sprite_palette #(
    .IDX_W (PAL_W)
  ) u_palette (
    .clk   (Clk),
    .reset (Reset),
    .en    (pix_hit),
    .idx   (idx),
    .rgb   (rgb)
  );

  assign red   = rgb.r;
  assign green = rgb.g;
  assign blue  = rgb.b;

endmodule

// File: tb/tb_tree_sprite_renderer.sv
// tb_tree_sprite_renderer: directed self-checking bench for the tree
// sprite renderer, including a behavioural 1-cycle-latency frame RAM.
module tb_tree_sprite_renderer;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        frame_start;
  logic [9:0]  pos_x;
  logic [9:0]  pos_y;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic        pix_valid;
  logic [18:0] ram_addr;
  logic [4:0]  ram_data;
  logic        hit;
  logic [7:0]  red;
  logic [7:0]  green;
  logic [7:0]  blue;

  logic [4:0] mem [0:511];

  int checks = 0;
  int errors = 0;

  // Clock.
  always #5 Clk = ~Clk;

  // Frame RAM model: synchronous read, one cycle of latency.
  always @(posedge Clk) ram_data <= mem[ram_addr[8:0]];

  tree_sprite_renderer dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_start (frame_start),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .pix_valid   (pix_valid),
    .ram_addr    (ram_addr),
    .ram_data    (ram_data),
    .hit         (hit),
    .red         (red),
    .green       (green),
    .blue        (blue)
  );

  // ---------------- driver tasks ----------------

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    pix_valid   = 1'b0;
    frame_start = 1'b0;
    DrawX       = '0;
    DrawY       = '0;
  endtask

  task automatic set_pos(input logic [9:0] x, input logic [9:0] y);
    pos_x       = x;
    pos_y       = y;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  // Drive one pixel for one cycle, capture ram_addr one edge later and
  // hit/RGB three edges after the drive.
  task automatic send_pixel(input logic [9:0] x, input logic [9:0] y,
                            input logic v, input logic fs,
                            output logic [18:0] a, output logic h,
                            output logic [23:0] c);
    DrawX       = x;
    DrawY       = y;
    pix_valid   = v;
    frame_start = fs;
    step();
    a = ram_addr;
    idle_inputs();
    step();
    step();
    h = hit;
    c = {red, green, blue};
  endtask

  // ---------------- tests ----------------

  task automatic test_reset();
    Reset = 1'b1;
    idle_inputs();
    pos_x = '0;
    pos_y = '0;
    step();
    step();
    checks++;
    if (hit !== 1'b0) begin
      errors++; $display("FAIL reset_hit actual=%b required=0", hit);
    end
    checks++;
    if ({red, green, blue} !== 24'h0) begin
      errors++; $display("FAIL reset_rgb actual=%h required=000000", {red, green, blue});
    end
    checks++;
    if (ram_addr !== 19'd0) begin
      errors++; $display("FAIL reset_addr actual=%0d required=0", ram_addr);
    end
    Reset = 1'b0;
    step();
  endtask

  task automatic test_origin();
    logic [18:0] a; logic h; logic [23:0] c;
    set_pos(10'd100, 10'd200);
    send_pixel(10'd100, 10'd200, 1'b1, 1'b0, a, h, c);
    checks++;
    if (a !== 19'd0) begin
      errors++; $display("FAIL origin_addr actual=%0d required=0", a);
    end
    checks++;
    if (h !== 1'b1 || c !== 24'h3C963C) begin
      errors++; $display("FAIL origin_pix actual=%b/%h required=1/3c963c", h, c);
    end
    send_pixel(10'd102, 10'd200, 1'b1, 1'b0, a, h, c);
    checks++;
    if (a !== 19'd2 || h !== 1'b1 || c !== 24'h1E5A1E) begin
      errors++; $display("FAIL idx1_pix actual=%0d/%b/%h required=2/1/1e5a1e", a, h, c);
    end
  endtask

  task automatic test_corner();
    logic [18:0] a; logic h; logic [23:0] c;
    send_pixel(10'd119, 10'd219, 1'b1, 1'b0, a, h, c);
    checks++;
    if (a !== 19'd399) begin
      errors++; $display("FAIL corner_addr actual=%0d required=399", a);
    end
    checks++;
    if (h !== 1'b1 || c !== 24'h6E4614) begin
      errors++; $display("FAIL corner_hi_bits actual=%b/%h required=1/6e4614", h, c);
    end
  endtask

  task automatic test_misses();
    logic [18:0] a; logic h; logic [23:0] c;
    logic [9:0] mx [4] = '{10'd120, 10'd99,  10'd100, 10'd100};
    logic [9:0] my [4] = '{10'd219, 10'd200, 10'd199, 10'd220};
    for (int i = 0; i < 4; i++) begin
      send_pixel(mx[i], my[i], 1'b1, 1'b0, a, h, c);
      checks++;
      if (a !== 19'd0 || h !== 1'b0 || c !== 24'h0) begin
        errors++;
        $display("FAIL miss_%0d_%0d actual=%0d/%b/%h required=0/0/000000", mx[i], my[i], a, h, c);
      end
    end
  endtask

  task automatic test_transparent();
    logic [18:0] a; logic h; logic [23:0] c;
    send_pixel(10'd101, 10'd200, 1'b1, 1'b0, a, h, c);
    checks++;
    if (a !== 19'd1 || h !== 1'b0 || c !== 24'h0) begin
      errors++; $display("FAIL transparent actual=%0d/%b/%h required=1/0/000000", a, h, c);
    end
    send_pixel(10'd100, 10'd200, 1'b0, 1'b0, a, h, c);
    checks++;
    if (a !== 19'd0 || h !== 1'b0 || c !== 24'h0) begin
      errors++; $display("FAIL pix_invalid actual=%0d/%b/%h required=0/0/000000", a, h, c);
    end
  endtask

  task automatic test_back_to_back();
    logic        exp_h [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [23:0] exp_c [6] = '{24'h78C850, 24'hFFFFFF, 24'h4A2C0A,
                               24'h0F3A0F, 24'h000000, 24'h000000};
    for (int i = 0; i < 8; i++) begin
      if (i < 6) begin
        DrawX     = 10'(100 + i);
        DrawY     = 10'd201;
        pix_valid = 1'b1;
      end else begin
        idle_inputs();
      end
      step();
      if (i < 6) begin
        checks++;
        if (ram_addr !== 19'(20 + i)) begin
          errors++; $display("FAIL b2b_addr_%0d actual=%0d required=%0d", i, ram_addr, 20 + i);
        end
      end
      if (i >= 2) begin
        checks++;
        if (hit !== exp_h[i-2] || {red, green, blue} !== exp_c[i-2]) begin
          errors++;
          $display("FAIL b2b_pix_%0d actual=%b/%h required=%b/%h",
                   i - 2, hit, {red, green, blue}, exp_h[i-2], exp_c[i-2]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    set_pos(10'd100, 10'd200);
    for (int i = 0; i < 3; i++) begin
      DrawX     = 10'(100 + i);
      DrawY     = 10'd201;
      pix_valid = 1'b1;
      step();
    end
    Reset = 1'b1;
    DrawX = 10'd103;
    step();
    checks++;
    if (hit !== 1'b0 || {red, green, blue} !== 24'h0 || ram_addr !== 19'd0) begin
      errors++;
      $display("FAIL midreset_clear actual=%b/%h/%0d required=0/000000/0", hit, {red, green, blue}, ram_addr);
    end
    Reset     = 1'b0;
    DrawX     = 10'd2;
    DrawY     = 10'd0;
    pix_valid = 1'b1;
    step();
    checks++;
    if (ram_addr !== 19'd2 || hit !== 1'b0) begin
      errors++; $display("FAIL midreset_rel1 actual=%0d/%b required=2/0", ram_addr, hit);
    end
    idle_inputs();
    step();
    checks++;
    if (hit !== 1'b0 || {red, green, blue} !== 24'h0) begin
      errors++; $display("FAIL midreset_rel2 actual=%b/%h required=0/000000", hit, {red, green, blue});
    end
    step();
    checks++;
    if (hit !== 1'b1 || {red, green, blue} !== 24'h1E5A1E) begin
      errors++; $display("FAIL midreset_rel3 actual=%b/%h required=1/1e5a1e", hit, {red, green, blue});
    end
  endtask

  task automatic test_shadow();
    logic [18:0] a; logic h; logic [23:0] c;
    set_pos(10'd100, 10'd200);
    pos_x = 10'd300;
    pos_y = 10'd50;
    step();
    send_pixel(10'd100, 10'd200, 1'b1, 1'b0, a, h, c);
    checks++;
    if (h !== 1'b1 || c !== 24'h3C963C) begin
      errors++; $display("FAIL shadow_hold actual=%b/%h required=1/3c963c", h, c);
    end
    send_pixel(10'd100, 10'd200, 1'b1, 1'b1, a, h, c);
    checks++;
    if (h !== 1'b1 || c !== 24'h3C963C) begin
      errors++; $display("FAIL shadow_same_cycle actual=%b/%h required=1/3c963c", h, c);
    end
    send_pixel(10'd100, 10'd200, 1'b1, 1'b0, a, h, c);
    checks++;
    if (a !== 19'd0 || h !== 1'b0 || c !== 24'h0) begin
      errors++; $display("FAIL shadow_old_pos actual=%0d/%b/%h required=0/0/000000", a, h, c);
    end
    send_pixel(10'd300, 10'd50, 1'b1, 1'b0, a, h, c);
    checks++;
    if (a !== 19'd0 || h !== 1'b1 || c !== 24'h3C963C) begin
      errors++; $display("FAIL shadow_new_pos actual=%0d/%b/%h required=0/1/3c963c", a, h, c);
    end
  endtask

  task automatic test_no_wrap();
    logic [18:0] a; logic h; logic [23:0] c;
    set_pos(10'd1015, 10'd0);
    send_pixel(10'd3, 10'd5, 1'b1, 1'b0, a, h, c);
    checks++;
    if (a !== 19'd0 || h !== 1'b0 || c !== 24'h0) begin
      errors++; $display("FAIL no_wrap actual=%0d/%b/%h required=0/0/000000", a, h, c);
    end
    send_pixel(10'd1019, 10'd5, 1'b1, 1'b0, a, h, c);
    checks++;
    if (a !== 19'd104 || h !== 1'b1 || c !== 24'h78C850) begin
      errors++; $display("FAIL edge_onscreen actual=%0d/%b/%h required=104/1/78c850", a, h, c);
    end
  endtask

  task automatic test_scale2();
    logic [18:0] a; logic h; logic [23:0] c;
    set_pos(10'd100, 10'd200);
    send_pixel(10'd139, 10'd239, 1'b1, 1'b0, a, h, c);
    checks++;
    if (a !== 19'd399 || h !== 1'b1 || c !== 24'h6E4614) begin
      errors++; $display("FAIL scale_corner actual=%0d/%b/%h required=399/1/6e4614", a, h, c);
    end
    send_pixel(10'd101, 10'd201, 1'b1, 1'b0, a, h, c);
    checks++;
    if (a !== 19'd0 || h !== 1'b1 || c !== 24'h3C963C) begin
      errors++; $display("FAIL scale_origin actual=%0d/%b/%h required=0/1/3c963c", a, h, c);
    end
    send_pixel(10'd140, 10'd200, 1'b1, 1'b0, a, h, c);
    checks++;
    if (a !== 19'd0 || h !== 1'b0 || c !== 24'h0) begin
      errors++; $display("FAIL scale_miss actual=%0d/%b/%h required=0/0/000000", a, h, c);
    end
  endtask

  // ---------------- sequence and report ----------------

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 5'd0;
    mem[0]   = 5'd2;
    mem[1]   = 5'd0;
    mem[2]   = 5'd1;
    mem[20]  = 5'd4;
    mem[21]  = 5'd7;
    mem[22]  = 5'd5;
    mem[23]  = 5'd6;
    mem[104] = 5'd4;
    mem[112] = 5'd7;
    mem[399] = 5'b11_011;

    Reset = 1'b1;
    idle_inputs();
    pos_x = '0;
    pos_y = '0;

    test_reset();
`ifdef TREE_SCALE2_EN
    test_scale2();
`else
    test_origin();
    test_corner();
    test_misses();
    test_transparent();
    test_back_to_back();
    test_reset_mid();
    test_shadow();
    test_no_wrap();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
